// File: rtl/uart_rx_fifo_receiver_pkg.sv
// Shared types and constants for the console UART receiver.
// Frame width and receive FSM state encoding.
package uart_rx_fifo_receiver_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO holding received UART bytes.
// Registered count; head is forced to zero while empty.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              do_push;
  logic              do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full push needs
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_receiver.sv
// 8N1 console UART receiver with mid-bit sampling and byte FIFO.
// Sticky overrun / framing flags, busy while a frame is in flight.
module uart_rx_fifo_receiver
  import uart_rx_fifo_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 650,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rst_n_i,
  input  logic                   uart_rx_i,
  output logic [UART_DATA_W-1:0] uart_dat_o,
  output logic                   uart_valid_o,
  input  logic                   uart_rd_i,
  output logic                   uart_overrun_o,
  output logic                   uart_frame_err_o,
  input  logic                   uart_err_clr_i,
  output logic                   uart_rx_busy_o
);

  localparam int DW = $clog2(CLKS_PER_BIT + 1);

  rx_state_e              state, state_n;
  logic [DW-1:0]          div, div_n;
  logic [2:0]             bit_cnt, bit_n;
  logic [UART_DATA_W-1:0] sh, sh_n;
  logic                   rx_meta, rx_s, rx_q;
  logic                   expire;
  logic                   push, ferr_set, ovr_set;
  logic                   fifo_full, fifo_empty;

  // rx_q tracks the previous rx_s so a held-low line never re-arms
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  assign expire = (div == '0);

  always_comb begin
    state_n  = state;
    div_n    = expire ? div : div - 1'b1;
    bit_n    = bit_cnt;
    sh_n     = sh;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rx_q && !rx_s) begin
          state_n = ST_START;
          bit_n   = '0;
          div_n   = DW'(CLKS_PER_BIT / 2);
        end
      end
      ST_START: begin
        if (expire) begin
          state_n = rx_s ? ST_IDLE : ST_DATA;
          div_n   = DW'(CLKS_PER_BIT - 1);
        end
      end
      ST_DATA: begin
        if (expire) begin
          sh_n  = {rx_s, sh[UART_DATA_W-1:1]};
          bit_n = bit_cnt + 3'd1;
          div_n = DW'(CLKS_PER_BIT - 1);
          if (bit_cnt == 3'd7) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (expire) begin
          state_n  = ST_IDLE;
          push     = rx_s;
          ferr_set = !rx_s;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state   <= ST_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      bit_cnt <= bit_n;
      sh      <= sh_n;
    end
  end

  assign ovr_set = push && fifo_full && !uart_rd_i;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      uart_overrun_o   <= 1'b0;
      uart_frame_err_o <= 1'b0;
    end else begin
      if (ovr_set)             uart_overrun_o <= 1'b1;
      else if (uart_err_clr_i) uart_overrun_o <= 1'b0;
      if (ferr_set)            uart_frame_err_o <= 1'b1;
      else if (uart_err_clr_i) uart_frame_err_o <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DATA_W (UART_DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk_i),
    .rst_n (sys_rst_n_i),
    .push  (push),
    .pop   (uart_rd_i),
    .wdata (sh),
    .rdata (uart_dat_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign uart_valid_o   = !fifo_empty;
  assign uart_rx_busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_receiver.sv
// Randomised bench for the console UART receiver.
// Serial driver plus queue model of bytes and sticky flags.
module tb_uart_rx_fifo_receiver;

  localparam int C = 16;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] dat;
  logic       valid;
  logic       rd;
  logic       ovr;
  logic       ferr;
  logic       clr;
  logic       busy;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] q[$];
  logic       exp_ovr = 1'b0;
  logic       exp_ferr = 1'b0;
  int         rise = -1;
  int         stop_k = 0;
  int         seen;

  always #5 clk = ~clk;

  uart_rx_fifo_receiver #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .sys_clk_i        (clk),
    .sys_rst_n_i      (rst_n),
    .uart_rx_i        (rx),
    .uart_dat_o       (dat),
    .uart_valid_o     (valid),
    .uart_rd_i        (rd),
    .uart_overrun_o   (ovr),
    .uart_frame_err_o (ferr),
    .uart_err_clr_i   (clr),
    .uart_rx_busy_o   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      tick(C);
    end
    if (!stop) exp_ferr = 1'b1;
    else if (q.size() < D) q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic pop_one();
    chk("valid", valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("dat", dat, q[0]);
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
      void'(q.pop_front());
    end
  endtask

  task automatic drain();
    while (q.size() != 0) pop_one();
    chk("empty", valid, 1'b0);
  endtask

  task automatic flags(input string tag);
    chk({tag, "_ovr"}, ovr, exp_ovr);
    chk({tag, "_ferr"}, ferr, exp_ferr);
  endtask

  task automatic err_clear();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_ovr = 1'b0;
    exp_ferr = 1'b0;
    flags("clr");
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    rd = 1'b0;
    clr = 1'b0;
    tick(3);
    chk("rst_valid", valid, 1'b0);
    chk("rst_dat", dat, 8'h00);
    chk("rst_busy", busy, 1'b0);
    flags("rst");
    rst_n = 1'b1;
    tick(2);

    // single frame, locate the stop-sample cycle from valid rising
    fork
      send_frame(8'hA5, 1'b1);
      for (int k = 1; k <= 10 * C; k++) begin
        @(negedge clk);
        if (valid && rise < 0) rise = k;
      end
    join
    chk("a5_rise_win", (rise >= 9 * C + 2) && (rise <= 10 * C), 1'b1);
    stop_k = rise - 1;
    chk("a5_dat", dat, 8'hA5);
    flags("a5");
    drain();

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'h81, 1'b1);
    flags("b2b");
    drain();

    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
    flags("ovr");
    drain();
    err_clear();

    // short low glitch on an idle line
    seen = 0;
    rx = 1'b0;
    for (int k = 0; k < C; k++) begin
      if (k == C / 4) rx = 1'b1;
      tick(1);
      if (busy) seen = 1;
    end
    chk("glitch_seen", seen, 1);
    chk("glitch_busy", busy, 1'b0);
    chk("glitch_valid", valid, 1'b0);
    flags("glitch");
    tick(C);

    // bad stop bit, then line held low (break)
    send_frame(8'h3C, 1'b0);
    seen = 0;
    for (int k = 0; k < 3 * C; k++) begin
      tick(1);
      if (busy) seen = 1;
    end
    chk("break_busy", seen, 0);
    chk("break_valid", valid, 1'b0);
    flags("ferr");
    rx = 1'b1;
    tick(C);
    err_clear();
    send_frame(8'h5A, 1'b1);
    flags("post_break");
    drain();

    // full FIFO with a pop on the push cycle
    for (int i = 0; i < D; i++) send_frame(8'($urandom), 1'b1);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        tick(stop_k);
        chk("same_dat", dat, q[0]);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        void'(q.pop_front());
      end
    join
    chk("same_cnt", q.size(), D);
    chk("same_last", q[D-1], 8'h7E);
    flags("same");
    drain();

    // asynchronous reset in the middle of a data bit
    send_frame(8'h99, 1'b1);
    rx = 1'b0;
    tick(C);
    rx = 1'b1;
    tick(C + 3);
    chk("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 1'b0);
    chk("arst_dat", dat, 8'h00);
    chk("arst_busy", busy, 1'b0);
    q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(C);
    send_frame(8'h12, 1'b1);
    chk("post_rst_dat", dat, 8'h12);
    flags("post_rst");
    drain();

    for (int i = 0; i < 256; i++) begin
      send_frame(8'($urandom), 1'b1);
      if (q.size() == D || $urandom_range(0, 1) == 1) pop_one();
      if ($urandom_range(0, 3) == 0) pop_one();
    end
    flags("loop");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
